// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, fetch state encoding and PC step for the fetch sequencer
package fetch_ctrl_pkg;
  localparam int ADDR_SIZE = 31;
  localparam int INSTR_SIZE = 31;
  localparam int ADDR_W = ADDR_SIZE + 1;
  localparam int INSTR_W = INSTR_SIZE + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer driving a registered-address imem and a valid/ready decode port
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RESET_PC  = 0,
  parameter int MEM_WORDS = 64,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_err,
  output logic [CNT_W-1:0]   fetch_count,
  output logic               busy
);
  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_redir;
  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;
  // next state plus issue decision; a redirect outside IDLE always issues, even while halted
  always_comb begin
    w_accept = r_valid && out_ready;
    w_redir = redirect_valid && (r_state != FS_IDLE);
    w_issue = w_redir || ((r_state == FS_RUN) && !halt && (!r_valid || out_ready));
    w_addr = w_redir ? redirect_pc : r_pc;
    w_state_nxt = (r_state == FS_IDLE)   ? (start ? FS_RUN : FS_IDLE) :
                  (r_state == FS_RUN)    ? ((halt && !redirect_valid) ? FS_HALTED : FS_RUN) :
                  (r_state == FS_HALTED) ? (halt ? FS_HALTED : FS_RUN) : FS_IDLE;
  end
  // state, PC and presented fetch; the imem holds its data while enable is low so no buffer is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FS_IDLE;
      r_pc <= ADDR_W'(RESET_PC);
      r_out_pc <= ADDR_W'(RESET_PC);
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_valid <= 1'b1;
        r_out_pc <= w_addr;
        r_pc <= w_addr + PC_INC;
      end else begin
        if (w_accept) r_valid <= 1'b0;
        if ((r_state == FS_IDLE) && redirect_valid) r_pc <= redirect_pc;
      end
    end
  end
  // retired-fetch counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign imem_en = w_issue;
  assign imem_addr = w_addr;
  assign out_valid = r_valid;
  assign out_pc = r_out_pc;
  assign out_instr = imem_data;
  assign out_err = r_valid && ((r_out_pc[1:0] != 2'b00) || (r_out_pc[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS)));
  assign fetch_count = r_cnt;
  assign busy = r_state != FS_IDLE;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic against a transaction-level fetch model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc, fetch_count;
  logic imem_en, out_valid, out_err, busy;
  int vectors = 0, miscompares = 0;
  int m_mode = 0;
  logic m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_opc = '0, m_cnt = '0;
  logic e_en, a_en;
  logic [31:0] e_addr, a_addr;

  fetch_ctrl #(.RESET_PC(0), .MEM_WORDS(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_err(out_err), .fetch_count(fetch_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic exp_err(input logic v, input logic [31:0] p);
    return v && ((p[1:0] != 2'b00) || (p[31:2] >= 30'd64));
  endfunction

  always @(posedge clk) if (imem_en) imem_data <= mem_f(imem_addr);

  // one clock: drive inputs at negedge, snapshot the combinational fetch request, advance the model at posedge
  task automatic cyc(input logic st, input logic hl, input logic rv, input logic [31:0] rp,
                     input logic rdy, input logic rs);
    logic acc;
    @(negedge clk);
    start = st; halt = hl; redirect_valid = rv; redirect_pc = rp; out_ready = rdy; reset = rs;
    #1;
    a_en = imem_en; a_addr = imem_addr;
    e_en = (rv && m_mode != 0) || (m_mode == 1 && !hl && (!m_valid || rdy));
    e_addr = (rv && m_mode != 0) ? rp : m_pc;
    @(posedge clk);
    if (rs) begin
      m_mode = 0; m_pc = 32'd0; m_opc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    end else begin
      acc = m_valid && rdy;
      if (acc) m_cnt = m_cnt + 1;
      if (e_en) begin
        m_valid = 1'b1; m_opc = e_addr; m_pc = e_addr + 32'd4;
      end else begin
        if (acc) m_valid = 1'b0;
        if (m_mode == 0 && rv) m_pc = rp;
      end
      if (m_mode == 0) m_mode = st ? 1 : 0;
      else if (m_mode == 1) m_mode = (hl && !rv) ? 2 : 1;
      else m_mode = hl ? 2 : 1;
    end
    #1;
  endtask

  task automatic boot();
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    vectors++;
    if ({out_valid, busy, fetch_count, out_pc} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state got v=%b busy=%b cnt=%0d pc=%h exp v=0 busy=0 cnt=0 pc=0", out_valid, busy, fetch_count, out_pc);
    end
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({a_en, a_addr} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_idle_fetch got en=%b addr=%h exp en=0 addr=0", a_en, a_addr);
    end
  endtask

  task automatic test_sequential();
    boot();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      vectors++;
      if ({a_en, a_addr, out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * i), 1'b1, 32'(4 * i), mem_f(32'(4 * i))}) begin
        miscompares++;
        $display("FAIL seq_%0d got en=%b addr=%h v=%b pc=%h ins=%h exp addr=%h", i, a_en, a_addr, out_valid, out_pc, out_instr, 32'(4 * i));
      end
    end
    vectors++;
    if (fetch_count !== 32'd5) begin
      miscompares++;
      $display("FAIL seq_count got %0d exp 5", fetch_count);
    end
  endtask

  task automatic test_stall();
    boot();
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      vectors++;
      if ({a_en, out_valid, out_pc, out_instr, fetch_count} !== {1'b0, 1'b1, 32'h8, mem_f(32'h8), 32'd2}) begin
        miscompares++;
        $display("FAIL stall_%0d got en=%b v=%b pc=%h ins=%h cnt=%0d exp en=0 v=1 pc=8 cnt=2", i, a_en, out_valid, out_pc, out_instr, fetch_count);
      end
    end
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({out_pc, out_instr, fetch_count} !== {32'hC, mem_f(32'hC), 32'd3}) begin
      miscompares++;
      $display("FAIL stall_release got pc=%h cnt=%0d exp pc=c cnt=3", out_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] c;
    boot();
    for (int i = 0; i < 20 && !(m_valid && m_opc == 32'h10); i++) cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if (out_pc !== 32'h10) begin
      miscompares++;
      $display("FAIL redir_setup got pc=%h exp 10", out_pc);
    end
    c = fetch_count;
    cyc(0, 0, 1, 32'h20, 0, 0);
    vectors++;
    if ({a_en, a_addr, out_valid, out_pc, out_instr, fetch_count} !== {1'b1, 32'h20, 1'b1, 32'h20, mem_f(32'h20), c}) begin
      miscompares++;
      $display("FAIL redir_target got en=%b addr=%h pc=%h cnt=%0d exp addr=20 pc=20 cnt=%0d", a_en, a_addr, out_pc, fetch_count, c);
    end
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({out_pc, fetch_count} !== {32'h24, c + 32'd1}) begin
      miscompares++;
      $display("FAIL redir_follow got pc=%h cnt=%0d exp pc=24 cnt=%0d", out_pc, fetch_count, c + 1);
    end
  endtask

  task automatic test_halt();
    boot();
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 1, 0);
      vectors++;
      if ({a_en, out_valid, busy} !== {1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL halt_%0d got en=%b v=%b busy=%b exp en=0 v=0 busy=1", i, a_en, out_valid, busy);
      end
    end
    cyc(0, 1, 1, 32'h40, 1, 0);
    vectors++;
    if ({a_en, a_addr, out_valid, out_pc} !== {1'b1, 32'h40, 1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL halt_redir got en=%b addr=%h v=%b pc=%h exp en=1 addr=40 v=1 pc=40", a_en, a_addr, out_valid, out_pc);
    end
    cyc(0, 1, 0, 0, 1, 0);
    vectors++;
    if ({a_en, out_valid} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_single got en=%b v=%b exp en=0 v=0", a_en, out_valid);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({a_en, a_addr, out_pc} !== {1'b1, 32'h44, 32'h44}) begin
      miscompares++;
      $display("FAIL halt_resume got en=%b addr=%h pc=%h exp en=1 addr=44 pc=44", a_en, a_addr, out_pc);
    end
  endtask

  task automatic test_err();
    logic [31:0] tgt [3] = '{32'h102, 32'h100, 32'hFC};
    logic exp [3] = '{1'b1, 1'b1, 1'b0};
    boot();
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, tgt[i], 1, 0);
      vectors++;
      if ({out_pc, out_valid, out_err} !== {tgt[i], 1'b1, exp[i]}) begin
        miscompares++;
        $display("FAIL err_%h got pc=%h v=%b err=%b exp err=%b", tgt[i], out_pc, out_valid, out_err, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    boot();
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    vectors++;
    if ({out_valid, out_pc, fetch_count, busy} !== {1'b0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid got v=%b pc=%h cnt=%0d busy=%b exp all 0", out_valid, out_pc, fetch_count, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      vectors++;
      if ({a_en, a_addr, out_valid} !== {1'b0, 32'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL rst_mid_idle_%0d got en=%b addr=%h v=%b exp en=0 addr=0 v=0", i, a_en, a_addr, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic hl = 1'b0;
    logic [31:0] rp;
    boot();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) hl = ~hl;
      rp = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 400)) : 32'($urandom_range(0, 80) * 4);
      cyc($urandom_range(0, 7) == 0, hl, $urandom_range(0, 5) == 0, rp, $urandom_range(0, 3) != 0,
          $urandom_range(0, 79) == 0);
      vectors++;
      if ({a_en, a_addr, out_valid, out_pc, fetch_count, busy, out_err} !==
          {e_en, e_addr, m_valid, m_opc, m_cnt, m_mode != 0, exp_err(m_valid, m_opc)}) begin
        miscompares++;
        $display("FAIL rand_%0d got en=%b addr=%h v=%b pc=%h cnt=%0d busy=%b err=%b exp en=%b addr=%h v=%b pc=%h cnt=%0d busy=%b err=%b",
                 i, a_en, a_addr, out_valid, out_pc, fetch_count, busy, out_err,
                 e_en, e_addr, m_valid, m_opc, m_cnt, m_mode != 0, exp_err(m_valid, m_opc));
      end
      if (m_valid) begin
        vectors++;
        if (out_instr !== mem_f(m_opc)) begin
          miscompares++;
          $display("FAIL rand_instr_%0d got %h exp %h", i, out_instr, mem_f(m_opc));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the instruction memory's addr/enable pair and presents fetched instructions to decode over a valid/ready handshake.
- Owns the PC, sequential increment, branch/jump redirect, halt/stall and a retired-fetch counter.
- Sits between the instruction memory and the decode stage.
- Exploits the memory's registered-address read: data is valid one cycle after enable, and stays stable while enable is low. Because of this, no instruction buffer is needed.

Parameters:
RESET_PC, 0, PC loaded on reset.
MEM_WORDS, 64, instruction memory depth in 32-bit words; addresses at or beyond this range are flagged.
CNT_W, 32, width of fetch counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE and begins fetching
halt  in  1  level; while high, no new fetches are issued
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  `ADDR_SIZE+1  redirect target
imem_addr  out  `ADDR_SIZE+1  to imem addr
imem_en  out  1  to imem enable
imem_data  in  `INSTR_SIZE+1  from imem data
out_valid  out  1  instruction valid to decode
out_ready  in  1  decode accepts
out_instr  out  `INSTR_SIZE+1  instruction (= imem_data passthrough)
out_pc  out  `ADDR_SIZE+1  PC of out_instr
out_err  out  1  fetch fault: out_pc[1:0]!=0 or out_pc[ADDR:2]>=MEM_WORDS
fetch_count  out  CNT_W  number of accepted handshakes
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, pc_q=RESET_PC, out_valid=0, out_pc=RESET_PC, fetch_count=0, imem_en=0.
- Reset mid-operation squashes any in-flight fetch; out_valid is 0 the cycle after reset.
- Definitions:
  - accept = out_valid & out_ready.
  - can_issue = (state==RUN) & !halt & (!out_valid | out_ready).
- imem_en / imem_addr (combinational):
  - redirect_valid & state!=IDLE: imem_en=1, imem_addr=redirect_pc.
  - else can_issue: imem_en=1, imem_addr=pc_q.
  - else imem_en=0, imem_addr=pc_q.
- On each issue (registered):
  - out_valid<=1.
  - out_pc<=issued address.
  - pc_q<=issued address + 4.
- No issue and accept: out_valid<=0.
- No issue and no accept: out_valid, out_pc hold. imem data stays stable because enable is low.
- Latency: issue at cycle N gives out_valid=1 with the matching instruction at N+1. Back-to-back issue sustains 1 instruction/cycle while out_ready=1.
- Redirect:
  - Has priority over sequential fetch and ignores halt for that cycle.
  - The instruction presented in the same cycle still completes if out_ready=1 (counted).
  - If out_ready=0 it is discarded: it is replaced by the target next cycle.
  - In IDLE, redirect only loads pc_q<=redirect_pc; no fetch.
- States:
  - IDLE -> RUN on start.
  - RUN -> HALTED when halt=1 and no redirect.
  - HALTED -> RUN when halt=0.
  - Any -> IDLE on reset only.
  - HALTED keeps out_valid/out_pc until accepted; it issues only on redirect.
- out_err is computed from out_pc combinationally and qualified by out_valid (0 when !out_valid).
  - The faulting fetch is still presented; decode handles the trap.
  - The controller keeps incrementing.
- fetch_count increments on accept and wraps at 2^CNT_W.
- PC arithmetic is modulo 2^(`ADDR_SIZE+1); wrap-around is silent but flagged via out_err range check.
- start while not IDLE is ignored. Simultaneous start & halt: go RUN; halt then blocks issue in the next cycle.

Decomposition:
- Shared package/include (def_params.v): `ADDR_SIZE, `INSTR_SIZE, fetch state encodings (FS_IDLE=2'd0, FS_RUN=2'd1, FS_HALTED=2'd2), PC increment constant 4.
- Single module; no sub-module needed. fetch_count may optionally be a trivial counter instance but stays inline.

Test Plan:
1. reset 3 cycles, start pulse, out_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; out_pc 0 at cycle after first issue; fetch_count=5 after 5 accepts.
2. out_ready=0 for 3 cycles at out_pc=8 -> imem_en=0, out_valid=1, out_pc=8, out_instr unchanged; release -> next out_pc=12, no instruction skipped or duplicated.
3. redirect_valid with redirect_pc=0x20 while out_pc=0x10, out_ready=0 -> next cycle out_pc=0x20, 0x10 dropped, count unchanged; following pc 0x24.
4. halt=1 in RUN -> state HALTED, no further imem_en; redirect_pc=0x40 while halted -> single fetch, out_pc=0x40; halt=0 -> resume at 0x44.
5. redirect_pc=0x102 -> out_err=1 with out_pc=0x102; redirect_pc=0x100 (word 64, MEM_WORDS=64) -> out_err=1; 0xFC -> out_err=0.
6. reset asserted while out_valid=1 mid-stream -> next cycle out_valid=0, pc=RESET_PC, fetch_count=0, state IDLE; no fetch until start.
